// File: rtl/io_supply_seq.sv
// ----------------------------------------------------------------------------
// io_supply_seq
//
// Sequencer for the pad-ring supply segments (VDDQ/VSSQ banks) of the IO ring.
// Power-up walks the segments in ascending order: the switch of a segment is
// enabled, its synchronised power-good is debounced, and only then is that
// segment's pad isolation released and the next switch enabled. Power-down
// walks the segments in descending order, isolating a segment one cycle
// before its switch is opened. While fully on, every segment is watched for
// brown-out; a brown-out or a ramp timeout drops the whole ring into a safe
// state (everything isolated, every switch open) with a sticky error flag.
//
// Ports
//   clk         single clock
//   rst         synchronous, active-high reset
//   req_on      start power-up (level-sampled)
//   req_off     start power-down / clear a fault (level-sampled, wins over req_on)
//   pgood_i     raw per-segment power-good, asynchronous to clk
//   deb_cycles  debounce length in cycles (0 behaves as 1)
//   tmo_cycles  ramp timeout in cycles (0 disables the timeout)
//   sw_en_o     per-segment power-switch enable, 1 = on
//   iso_o       per-segment pad isolation, 1 = isolated
//   busy_o      ramping up or powering down
//   ready_o     all segments up
//   err_o       sticky fault flag
//   err_ch_o    segment that caused the last fault
// ----------------------------------------------------------------------------
module io_supply_seq #(
    parameter int N_CH  = 4,
    parameter int DEB_W = 4,
    parameter int TMO_W = 12,
    parameter int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_on,
    input  logic              req_off,
    input  logic [N_CH-1:0]   pgood_i,
    input  logic [DEB_W-1:0]  deb_cycles,
    input  logic [TMO_W-1:0]  tmo_cycles,
    output logic [N_CH-1:0]   sw_en_o,
    output logic [N_CH-1:0]   iso_o,
    output logic              busy_o,
    output logic              ready_o,
    output logic              err_o,
    output logic [CH_W-1:0]   err_ch_o
);

    typedef enum logic [2:0] {
        ST_OFF   = 3'd0,
        ST_RAMP  = 3'd1,
        ST_ON    = 3'd2,
        ST_DOWN  = 3'd3,
        ST_FAULT = 3'd4
    } state_t;

    localparam logic [CH_W-1:0]  LAST_CH  = CH_W'(N_CH - 1);
    localparam logic [CH_W-1:0]  CH_ZERO  = {CH_W{1'b0}};
    localparam logic [CH_W-1:0]  CH_ONE   = CH_W'(1);
    localparam logic [DEB_W-1:0] DEB_ZERO = {DEB_W{1'b0}};
    localparam logic [DEB_W-1:0] DEB_ONE  = DEB_W'(1);
    localparam logic [TMO_W-1:0] TMO_ZERO = {TMO_W{1'b0}};
    localparam logic [N_CH-1:0]  ALL_ZERO = {N_CH{1'b0}};
    localparam logic [N_CH-1:0]  ALL_ONE  = {N_CH{1'b1}};

    // FSM state and sequencing index
    state_t             state_r;
    state_t             state_nxt;
    logic               down_b_r;     // DOWN: 0 = isolate phase, 1 = switch-off phase
    logic               down_b_nxt;
    logic [CH_W-1:0]    idx_r;
    logic [CH_W-1:0]    idx_nxt;

    // Datapath registers
    logic [N_CH-1:0]    sync1_r;
    logic [N_CH-1:0]    pg_r;
    logic [DEB_W-1:0]   deb_cnt_r;
    logic [DEB_W-1:0]   deb_cnt_nxt;
    logic [TMO_W-1:0]   timer_r;
    logic [TMO_W-1:0]   timer_nxt;
    logic [DEB_W-1:0]   bo_cnt_r   [N_CH];
    logic [DEB_W-1:0]   bo_cnt_nxt [N_CH];

    // Registered outputs
    logic [N_CH-1:0]    sw_en_r;
    logic [N_CH-1:0]    sw_en_nxt;
    logic [N_CH-1:0]    iso_r;
    logic [N_CH-1:0]    iso_nxt;
    logic               busy_r;
    logic               busy_nxt;
    logic               ready_r;
    logic               ready_nxt;
    logic               err_r;
    logic               err_nxt;
    logic [CH_W-1:0]    err_ch_r;
    logic [CH_W-1:0]    err_ch_nxt;

    // Decode helpers
    logic [DEB_W-1:0]   deb_eff_s;
    logic [DEB_W:0]     deb_sum_s;
    logic               deb_done_s;
    logic [TMO_W:0]     tmr_sum_s;
    logic               tmo_hit_s;
    logic [N_CH-1:0]    bo_hit_s;
    logic               bo_any_s;
    logic [CH_W-1:0]    bo_ch_s;
    logic [CH_W-1:0]    idx_inc_s;
    logic [CH_W-1:0]    idx_dec_s;

    assign sw_en_o  = sw_en_r;
    assign iso_o    = iso_r;
    assign busy_o   = busy_r;
    assign ready_o  = ready_r;
    assign err_o    = err_r;
    assign err_ch_o = err_ch_r;

    assign idx_inc_s = idx_r + CH_ONE;
    assign idx_dec_s = idx_r - CH_ONE;

    // Ramp debounce/timeout decode. The debounce completes on the edge that
    // takes the count to deb_cycles, so the current sample is included; the
    // timeout works the same way, and a completing debounce beats a timeout.
    always_comb begin
        deb_eff_s  = (deb_cycles == DEB_ZERO) ? DEB_ONE : deb_cycles;
        deb_sum_s  = {1'b0, deb_cnt_r} + {{DEB_W{1'b0}}, 1'b1};
        deb_done_s = pg_r[idx_r] && (deb_sum_s >= {1'b0, deb_eff_s});
        tmr_sum_s  = {1'b0, timer_r} + {{TMO_W{1'b0}}, 1'b1};
        tmo_hit_s  = (tmo_cycles != TMO_ZERO) && (tmr_sum_s >= {1'b0, tmo_cycles})
                     && !deb_done_s;
    end

    // Brown-out decode: a segment faults once its registered low-count holds
    // deb_cycles; the lowest faulting segment is reported.
    always_comb begin
        bo_ch_s = CH_ZERO;
        for (int k = 0; k < N_CH; k++) begin
            bo_hit_s[k] = (bo_cnt_r[k] >= deb_eff_s);
        end
        for (int k = N_CH - 1; k >= 0; k--) begin
            if (bo_hit_s[k]) begin
                bo_ch_s = CH_W'(k);
            end else begin
                bo_ch_s = bo_ch_s;
            end
        end
        bo_any_s = |bo_hit_s;
    end

    // State register: FSM state, DOWN phase and segment index
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= ST_OFF;
            down_b_r <= 1'b0;
            idx_r    <= CH_ZERO;
        end else begin
            state_r  <= state_nxt;
            down_b_r <= down_b_nxt;
            idx_r    <= idx_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt  = state_r;
        down_b_nxt = down_b_r;
        idx_nxt    = idx_r;
        case (state_r)
            ST_OFF: begin
                if (req_on && !req_off) begin
                    state_nxt = ST_RAMP;
                    idx_nxt   = CH_ZERO;
                end else begin
                    state_nxt = ST_OFF;
                end
            end
            ST_RAMP: begin
                if (req_off) begin
                    // Entry edge already isolates idx, so continue with switch-off
                    state_nxt  = ST_DOWN;
                    down_b_nxt = 1'b1;
                end else if (deb_done_s) begin
                    if (idx_r == LAST_CH) begin
                        state_nxt = ST_ON;
                    end else begin
                        idx_nxt = idx_inc_s;
                    end
                end else if (tmo_hit_s) begin
                    state_nxt = ST_FAULT;
                end else begin
                    state_nxt = ST_RAMP;
                end
            end
            ST_ON: begin
                if (bo_any_s) begin
                    state_nxt = ST_FAULT;
                end else if (req_off) begin
                    state_nxt  = ST_DOWN;
                    down_b_nxt = 1'b1;
                    idx_nxt    = LAST_CH;
                end else begin
                    state_nxt = ST_ON;
                end
            end
            ST_DOWN: begin
                if (!down_b_r) begin
                    down_b_nxt = 1'b1;
                end else begin
                    down_b_nxt = 1'b0;
                    if (idx_r == CH_ZERO) begin
                        state_nxt = ST_OFF;
                    end else begin
                        idx_nxt = idx_dec_s;
                    end
                end
            end
            ST_FAULT: begin
                if (req_off) begin
                    state_nxt = ST_OFF;
                    idx_nxt   = CH_ZERO;
                end else begin
                    state_nxt = ST_FAULT;
                end
            end
            default: begin
                state_nxt  = ST_FAULT;
                down_b_nxt = 1'b0;
                idx_nxt    = CH_ZERO;
            end
        endcase
    end

    // Output logic: next values of the registered outputs
    always_comb begin
        sw_en_nxt  = sw_en_r;
        iso_nxt    = iso_r;
        busy_nxt   = busy_r;
        ready_nxt  = ready_r;
        err_nxt    = err_r;
        err_ch_nxt = err_ch_r;
        case (state_r)
            ST_OFF: begin
                if (req_on && !req_off) begin
                    sw_en_nxt[0] = 1'b1;
                    busy_nxt     = 1'b1;
                end else begin
                    busy_nxt = 1'b0;
                end
            end
            ST_RAMP: begin
                if (req_off) begin
                    iso_nxt[idx_r] = 1'b1;
                end else if (deb_done_s) begin
                    iso_nxt[idx_r] = 1'b0;
                    if (idx_r == LAST_CH) begin
                        busy_nxt  = 1'b0;
                        ready_nxt = 1'b1;
                    end else begin
                        sw_en_nxt[idx_inc_s] = 1'b1;
                    end
                end else if (tmo_hit_s) begin
                    sw_en_nxt  = ALL_ZERO;
                    iso_nxt    = ALL_ONE;
                    busy_nxt   = 1'b0;
                    ready_nxt  = 1'b0;
                    err_nxt    = 1'b1;
                    err_ch_nxt = idx_r;
                end else begin
                    busy_nxt = 1'b1;
                end
            end
            ST_ON: begin
                if (bo_any_s) begin
                    sw_en_nxt  = ALL_ZERO;
                    iso_nxt    = ALL_ONE;
                    busy_nxt   = 1'b0;
                    ready_nxt  = 1'b0;
                    err_nxt    = 1'b1;
                    err_ch_nxt = bo_ch_s;
                end else if (req_off) begin
                    iso_nxt[LAST_CH] = 1'b1;
                    busy_nxt         = 1'b1;
                    ready_nxt        = 1'b0;
                end else begin
                    ready_nxt = 1'b1;
                end
            end
            ST_DOWN: begin
                if (!down_b_r) begin
                    iso_nxt[idx_r] = 1'b1;
                end else begin
                    sw_en_nxt[idx_r] = 1'b0;
                    if (idx_r == CH_ZERO) begin
                        busy_nxt = 1'b0;
                    end else begin
                        busy_nxt = 1'b1;
                    end
                end
            end
            ST_FAULT: begin
                if (req_off) begin
                    err_nxt = 1'b0;
                end else begin
                    err_nxt = 1'b1;
                end
            end
            default: begin
                sw_en_nxt = ALL_ZERO;
                iso_nxt   = ALL_ONE;
                busy_nxt  = 1'b0;
                ready_nxt = 1'b0;
                err_nxt   = 1'b1;
            end
        endcase
    end

    // Datapath next values: ramp counters run only while staying on the same
    // segment; brown-out counters run only while ON and saturate.
    always_comb begin
        deb_cnt_nxt = DEB_ZERO;
        timer_nxt   = TMO_ZERO;
        if ((state_r == ST_RAMP) && (state_nxt == ST_RAMP) && (idx_nxt == idx_r)) begin
            if (pg_r[idx_r] && !(&deb_cnt_r)) begin
                deb_cnt_nxt = deb_sum_s[DEB_W-1:0];
            end else if (pg_r[idx_r]) begin
                deb_cnt_nxt = deb_cnt_r;
            end else begin
                deb_cnt_nxt = DEB_ZERO;
            end
            timer_nxt = (&timer_r) ? timer_r : tmr_sum_s[TMO_W-1:0];
        end else begin
            deb_cnt_nxt = DEB_ZERO;
            timer_nxt   = TMO_ZERO;
        end
        for (int k = 0; k < N_CH; k++) begin
            if ((state_r == ST_ON) && !pg_r[k]) begin
                bo_cnt_nxt[k] = (&bo_cnt_r[k]) ? bo_cnt_r[k] : (bo_cnt_r[k] + DEB_ONE);
            end else begin
                bo_cnt_nxt[k] = DEB_ZERO;
            end
        end
    end

    // Datapath registers: power-good synchroniser, debounce, timer, brown-out
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_r   <= ALL_ZERO;
            pg_r      <= ALL_ZERO;
            deb_cnt_r <= DEB_ZERO;
            timer_r   <= TMO_ZERO;
            for (int k = 0; k < N_CH; k++) begin
                bo_cnt_r[k] <= DEB_ZERO;
            end
        end else begin
            sync1_r   <= pgood_i;
            pg_r      <= sync1_r;
            deb_cnt_r <= deb_cnt_nxt;
            timer_r   <= timer_nxt;
            for (int k = 0; k < N_CH; k++) begin
                bo_cnt_r[k] <= bo_cnt_nxt[k];
            end
        end
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            sw_en_r  <= ALL_ZERO;
            iso_r    <= ALL_ONE;
            busy_r   <= 1'b0;
            ready_r  <= 1'b0;
            err_r    <= 1'b0;
            err_ch_r <= CH_ZERO;
        end else begin
            sw_en_r  <= sw_en_nxt;
            iso_r    <= iso_nxt;
            busy_r   <= busy_nxt;
            ready_r  <= ready_nxt;
            err_r    <= err_nxt;
            err_ch_r <= err_ch_nxt;
        end
    end

endmodule

// File: tb/tb_io_supply_seq.sv
// ----------------------------------------------------------------------------
// tb_io_supply_seq
//
// Self-checking bench for io_supply_seq (N_CH=4). Each scenario task pushes
// the expected per-edge output word {sw_en, iso, busy, ready, err, err_ch}
// into a queue as it drives stimulus, then pops and compares one word per
// clock edge. Inputs change on the falling edge; outputs are sampled there.
// Edge 1 of a scenario is the first rising edge that samples its request.
// ----------------------------------------------------------------------------
module tb_io_supply_seq;

    logic        clk;
    logic        rst;
    logic        req_on;
    logic        req_off;
    logic [3:0]  pgood_i;
    logic [3:0]  deb_cycles;
    logic [11:0] tmo_cycles;
    logic [3:0]  sw_en_o;
    logic [3:0]  iso_o;
    logic        busy_o;
    logic        ready_o;
    logic        err_o;
    logic [1:0]  err_ch_o;

    logic [14:0] obs;
    logic [14:0] exp_q[$];
    logic [14:0] expv;
    logic [1:0]  exp_ch;
    int          checks;
    int          passes;
    int          inv_bad;

    io_supply_seq #(.N_CH(4), .DEB_W(4), .TMO_W(12)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_on     (req_on),
        .req_off    (req_off),
        .pgood_i    (pgood_i),
        .deb_cycles (deb_cycles),
        .tmo_cycles (tmo_cycles),
        .sw_en_o    (sw_en_o),
        .iso_o      (iso_o),
        .busy_o     (busy_o),
        .ready_o    (ready_o),
        .err_o      (err_o),
        .err_ch_o   (err_ch_o)
    );

    assign obs = {sw_en_o, iso_o, busy_o, ready_o, err_o, err_ch_o};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Isolation may only be released on a segment whose switch is on
    always @(negedge clk) begin
        if ((~iso_o & ~sw_en_o) != 4'b0000) inv_bad++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [14:0] pk(input logic [3:0] sw, input logic [3:0] iso,
                                       input logic b, input logic r, input logic e,
                                       input logic [1:0] ch);
        return {sw, iso, b, r, e, ch};
    endfunction

    // Power-up with debounce d and good supplies: sw[k] rises at 1+d*k,
    // iso[k] falls at 1+d*(k+1), ready from 1+4d.
    function automatic logic [14:0] pu_exp(input int n, input int d);
        logic [3:0] sw;
        logic [3:0] iso;
        for (int k = 0; k < 4; k++) begin
            sw[k]  = (n >= 1 + d * k);
            iso[k] = !(n >= 1 + d * (k + 1));
        end
        return pk(sw, iso, (n >= 1) && (n < 1 + 4 * d), (n >= 1 + 4 * d), 1'b0, exp_ch);
    endfunction

    // Power-down from ON: iso[k] rises at 1+2(3-k), sw[k] falls at 2+2(3-k)
    function automatic logic [14:0] pd_exp(input int n);
        logic [3:0] sw;
        logic [3:0] iso;
        for (int k = 0; k < 4; k++) begin
            iso[k] = (n >= 1 + 2 * (3 - k));
            sw[k]  = (n < 2 + 2 * (3 - k));
        end
        return pk(sw, iso, (n < 8), 1'b0, 1'b0, exp_ch);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic test_reset();
        for (int n = 1; n <= 3; n++) exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        rst = 1'b1;
        for (int n = 1; n <= 3; n++) begin
            step();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL reset edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        rst = 1'b0;
        idle(4);
    endtask

    task automatic test_priority_off();
        for (int n = 1; n <= 4; n++) exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        req_on  = 1'b1;
        req_off = 1'b1;
        for (int n = 1; n <= 4; n++) begin
            step();
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL priority_off edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        req_on  = 1'b0;
        req_off = 1'b0;
    endtask

    task automatic test_power_up();
        for (int n = 1; n <= 15; n++) exp_q.push_back(pu_exp(n, 3));
        req_on = 1'b1;
        for (int n = 1; n <= 15; n++) begin
            step();
            req_on = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL power_up edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
    endtask

    task automatic test_brown_out();
        // Two low samples on segment 1: filtered out
        for (int m = 1; m <= 8; m++) exp_q.push_back(pk(4'hF, 4'h0, 1'b0, 1'b1, 1'b0, exp_ch));
        pgood_i = 4'b1101;
        for (int m = 1; m <= 8; m++) begin
            step();
            if (m == 2) pgood_i = 4'hF;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL brown_glitch edge %0d: got %h required %h", m, obs, expv);
            else passes++;
        end
        // Three low samples on segments 1 and 3: fault on segment 1 at edge 6
        for (int m = 1; m <= 7; m++) begin
            if (m < 6) exp_q.push_back(pk(4'hF, 4'h0, 1'b0, 1'b1, 1'b0, exp_ch));
            else       exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd1));
        end
        pgood_i = 4'b0101;
        for (int m = 1; m <= 7; m++) begin
            step();
            if (m == 3) pgood_i = 4'hF;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL brown_out edge %0d: got %h required %h", m, obs, expv);
            else passes++;
        end
        exp_ch = 2'd1;
        for (int m = 1; m <= 2; m++) exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, exp_ch));
        req_off = 1'b1;
        for (int m = 1; m <= 2; m++) begin
            step();
            req_off = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL fault_clear edge %0d: got %h required %h", m, obs, expv);
            else passes++;
        end
    endtask

    task automatic test_ramp_timeout();
        logic [3:0] sw;
        logic [3:0] iso;
        pgood_i    = 4'b1011;
        tmo_cycles = 12'd20;
        idle(4);
        for (int n = 1; n <= 28; n++) begin
            sw  = {1'b0, (n >= 7), (n >= 4), 1'b1};
            iso = {1'b1, 1'b1, (n < 7), (n < 4)};
            if (n < 27) exp_q.push_back(pk(sw, iso, 1'b1, 1'b0, 1'b0, exp_ch));
            else        exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b1, 2'd2));
        end
        req_on = 1'b1;
        for (int n = 1; n <= 28; n++) begin
            step();
            req_on = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL ramp_timeout edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        exp_ch = 2'd2;
        for (int n = 1; n <= 2; n++) exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, exp_ch));
        req_off = 1'b1;
        for (int n = 1; n <= 2; n++) begin
            step();
            req_off = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL timeout_clear edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        pgood_i    = 4'hF;
        tmo_cycles = 12'd100;
        idle(4);
    endtask

    task automatic test_deb_zero();
        deb_cycles = 4'd0;
        for (int n = 1; n <= 7; n++) exp_q.push_back(pu_exp(n, 1));
        req_on = 1'b1;
        for (int n = 1; n <= 7; n++) begin
            step();
            req_on = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL deb_zero edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
    endtask

    task automatic test_power_down();
        for (int n = 1; n <= 10; n++) exp_q.push_back(pd_exp(n));
        req_off = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            req_off = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL power_down edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        deb_cycles = 4'd3;
    endtask

    task automatic test_ramp_abort();
        for (int n = 1; n <= 10; n++) begin
            if (n <= 4)      exp_q.push_back(pu_exp(n, 3));
            else if (n == 5) exp_q.push_back(pk(4'b0011, 4'b1110, 1'b1, 1'b0, 1'b0, exp_ch));
            else if (n == 6) exp_q.push_back(pk(4'b0001, 4'b1110, 1'b1, 1'b0, 1'b0, exp_ch));
            else if (n == 7) exp_q.push_back(pk(4'b0001, 4'b1111, 1'b1, 1'b0, 1'b0, exp_ch));
            else             exp_q.push_back(pk(4'b0000, 4'b1111, 1'b0, 1'b0, 1'b0, exp_ch));
        end
        req_on = 1'b1;
        for (int n = 1; n <= 10; n++) begin
            step();
            req_on  = 1'b0;
            req_off = (n == 4);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL ramp_abort edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
    endtask

    task automatic test_reset_mid();
        for (int n = 1; n <= 9; n++) begin
            if (n <= 8) exp_q.push_back(pu_exp(n, 3));
            else        exp_q.push_back(pk(4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 2'd0));
        end
        req_on = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            step();
            req_on = 1'b0;
            rst    = (n == 8);
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL reset_mid edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
        exp_ch = 2'd0;
        idle(4);
        for (int n = 1; n <= 5; n++) exp_q.push_back(pu_exp(n, 3));
        req_on = 1'b1;
        for (int n = 1; n <= 5; n++) begin
            step();
            req_on = 1'b0;
            expv = exp_q.pop_front();
            checks++;
            if (obs !== expv) $display("FAIL restart edge %0d: got %h required %h", n, obs, expv);
            else passes++;
        end
    endtask

    task automatic test_invariant();
        checks++;
        if (inv_bad !== 0) $display("FAIL invariant: %0d cycles with iso=0 and sw_en=0, required 0", inv_bad);
        else passes++;
    endtask

    initial begin
        checks     = 0;
        passes     = 0;
        inv_bad    = 0;
        exp_ch     = 2'd0;
        rst        = 1'b1;
        req_on     = 1'b0;
        req_off    = 1'b0;
        pgood_i    = 4'hF;
        deb_cycles = 4'd3;
        tmo_cycles = 12'd100;
        @(negedge clk);
        test_reset();
        test_priority_off();
        test_power_up();
        test_brown_out();
        test_ramp_timeout();
        test_deb_zero();
        test_power_down();
        test_ramp_abort();
        test_reset_mid();
        test_invariant();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
